// File: rtl/ascon_host_pkg.sv
// ---------------------------------------------------------------------------
// ascon_host_pkg
// Shared definitions for the ASCON Avalon-MM host:
//   - word addresses of the ascon_wrapper slave register map
//   - mode encodings carried in the control word
//   - host FSM state enum
//   - cfg_word(): selects the 32-bit word written to a configuration address
// ---------------------------------------------------------------------------
package ascon_host_pkg;

    localparam logic [4:0] ADDR_CTRL     = 5'd0;
    localparam logic [4:0] ADDR_KEY0     = 5'd1;
    localparam logic [4:0] ADDR_NONCE0   = 5'd5;
    localparam logic [4:0] ADDR_AD0      = 5'd9;
    localparam logic [4:0] ADDR_DIN0     = 5'd13;
    localparam logic [4:0] ADDR_CFG_LAST = 5'd16;
    localparam logic [4:0] ADDR_STATUS   = 5'd17;
    localparam logic [4:0] ADDR_DOUT0    = 5'd18;
    localparam logic [4:0] ADDR_TAG0     = 5'd22;
    localparam logic [4:0] ADDR_RD_LAST  = ADDR_TAG0 + 5'd3;

    localparam logic [1:0] MODE_ENCRYPT  = 2'd0;
    localparam logic [1:0] MODE_DECRYPT  = 2'd1;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WR_CFG    = 4'd1,
        ST_WR_GO     = 4'd2,
        ST_WR_CLR    = 4'd3,
        ST_POLL_RD   = 4'd4,
        ST_POLL_CAP  = 4'd5,
        ST_POLL_WAIT = 4'd6,
        ST_RD_OUT    = 4'd7,
        ST_RESP      = 4'd8
    } host_state_e;

    // Word for configuration address 1..16. Each 128-bit field occupies four
    // consecutive addresses, most significant word at the lowest address.
    function automatic logic [31:0] cfg_word(
        input logic [127:0] key,
        input logic [127:0] nonce,
        input logic [127:0] ad,
        input logic [127:0] din,
        input logic [4:0]   addr
    );
        logic [127:0] field;
        logic [4:0]   base;
        logic [1:0]   off;
        if (addr >= ADDR_DIN0) begin
            field = din;   base = ADDR_DIN0;
        end else if (addr >= ADDR_AD0) begin
            field = ad;    base = ADDR_AD0;
        end else if (addr >= ADDR_NONCE0) begin
            field = nonce; base = ADDR_NONCE0;
        end else begin
            field = key;   base = ADDR_KEY0;
        end
        off = 2'(addr - base);
        return field[127 - 32 * int'(off) -: 32];
    endfunction

endpackage

// File: rtl/ascon_avmm_host.sv
// ---------------------------------------------------------------------------
// ascon_avmm_host
// Avalon-MM initiator that runs one ASCON AEAD job on the register-mapped
// ascon_wrapper slave: writes key/nonce/AD/data, pulses start, polls status,
// reads back output data and tag, and returns them on a response channel.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   req_*             job request (valid/ready), fields latched on accept
//   rsp_*             job result (valid/ready), held stable until accepted
//   chipselect/write/read/address/writedata/readdata
//                     Avalon-MM initiator; readdata valid 1 cycle after read
//
// Handshake: a transfer happens on the rising edge where valid && ready.
// rsp_valid does not depend on rsp_ready; req_ready does not depend on
// req_valid.
// ---------------------------------------------------------------------------
module ascon_avmm_host
    import ascon_host_pkg::*;
#(
    parameter int POLL_TIMEOUT = 1024,
    parameter int POLL_GAP     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_mode,
    input  logic [127:0] req_key,
    input  logic [127:0] req_nonce,
    input  logic [127:0] req_ad,
    input  logic [127:0] req_din,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_dout,
    output logic [127:0] rsp_tag,
    output logic         rsp_timeout,
    output logic         chipselect,
    output logic         write,
    output logic         read,
    output logic [4:0]   address,
    output logic [31:0]  writedata,
    input  logic [31:0]  readdata
);

    localparam logic [15:0] POLL_LIMIT  = 16'(POLL_TIMEOUT);
    localparam logic [15:0] GAP_LAST    = (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'd0;
    // RD_OUT runs one index past the last read to capture its data.
    localparam logic [4:0]  RD_DONE_IDX = ADDR_RD_LAST + 5'd1;

    host_state_e  r_state;
    host_state_e  w_next;
    logic [4:0]   r_idx;
    logic [1:0]   r_mode;
    logic [127:0] r_key;
    logic [127:0] r_nonce;
    logic [127:0] r_ad;
    logic [127:0] r_din;
    logic [15:0]  r_poll_cnt;
    logic [15:0]  r_gap_cnt;
    logic [255:0] r_out;      // {dout, tag}, filled MSW first
    logic         r_timeout;

    logic         w_write;
    logic         w_read;
    logic [4:0]   w_addr;
    logic [31:0]  w_wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_write = 1'b0;
        w_read  = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) w_next = ST_WR_CFG;
            end
            ST_WR_CFG: begin
                w_write = 1'b1;
                w_addr  = r_idx;
                w_wdata = cfg_word(r_key, r_nonce, r_ad, r_din, r_idx);
                if (r_idx == ADDR_CFG_LAST) w_next = ST_WR_GO;
            end
            ST_WR_GO: begin
                w_write = 1'b1;
                w_addr  = ADDR_CTRL;
                w_wdata = {29'd0, r_mode, 1'b1};
                w_next  = ST_WR_CLR;
            end
            ST_WR_CLR: begin
                w_write = 1'b1;
                w_addr  = ADDR_CTRL;
                w_wdata = {29'd0, r_mode, 1'b0};
                w_next  = ST_POLL_RD;
            end
            ST_POLL_RD: begin
                w_read = 1'b1;
                w_addr = ADDR_STATUS;
                w_next = ST_POLL_CAP;
            end
            ST_POLL_CAP: begin
                if (readdata[0])                w_next = ST_RD_OUT;
                else if (r_poll_cnt == POLL_LIMIT) w_next = ST_RESP;
                else if (POLL_GAP == 0)         w_next = ST_POLL_RD;
                else                            w_next = ST_POLL_WAIT;
            end
            ST_POLL_WAIT: begin
                if (r_gap_cnt == GAP_LAST) w_next = ST_POLL_RD;
            end
            ST_RD_OUT: begin
                // Reads are issued back-to-back; the last cycle only captures.
                if (r_idx <= ADDR_RD_LAST) begin
                    w_read = 1'b1;
                    w_addr = r_idx;
                end
                if (r_idx == RD_DONE_IDX) w_next = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_mode     <= '0;
            r_key      <= '0;
            r_nonce    <= '0;
            r_ad       <= '0;
            r_din      <= '0;
            r_poll_cnt <= '0;
            r_gap_cnt  <= '0;
            r_out      <= '0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_mode     <= req_mode;
                        r_key      <= req_key;
                        r_nonce    <= req_nonce;
                        r_ad       <= req_ad;
                        r_din      <= req_din;
                        r_idx      <= ADDR_KEY0;
                        r_poll_cnt <= '0;
                        r_out      <= '0;
                        r_timeout  <= 1'b0;
                    end
                end
                ST_WR_CFG: r_idx <= r_idx + 5'd1;
                ST_POLL_RD: begin
                    if (r_poll_cnt != 16'hFFFF) r_poll_cnt <= r_poll_cnt + 16'd1;
                    r_gap_cnt <= '0;
                end
                ST_POLL_CAP: begin
                    if (readdata[0]) begin
                        r_idx <= ADDR_DOUT0;
                    end else if (r_poll_cnt == POLL_LIMIT) begin
                        r_timeout <= 1'b1;
                        r_out     <= '0;
                    end
                end
                ST_POLL_WAIT: r_gap_cnt <= r_gap_cnt + 16'd1;
                ST_RD_OUT: begin
                    r_idx <= r_idx + 5'd1;
                    // Data for the read issued last cycle is on readdata now.
                    if (r_idx > ADDR_DOUT0) r_out <= {r_out[223:0], readdata};
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = rst_n && (r_state == ST_IDLE);
    assign rsp_valid   = (r_state == ST_RESP);
    assign rsp_dout    = r_out[255:128];
    assign rsp_tag     = r_out[127:0];
    assign rsp_timeout = r_timeout;
    assign chipselect  = w_write | w_read;
    assign write       = w_write;
    assign read        = w_read;
    assign address     = w_addr;
    assign writedata   = w_wdata;

endmodule

// File: tb/tb_ascon_avmm_host.sv
// ---------------------------------------------------------------------------
// tb_ascon_avmm_host
// Drives AEAD jobs into ascon_avmm_host, emulates the ascon_wrapper slave
// (status done after a chosen number of polls, random readback words), and
// checks bus traffic, timing and responses against a job-level model.
// ---------------------------------------------------------------------------
module tb_ascon_avmm_host;
    import ascon_host_pkg::*;

    localparam int TO  = 8;
    localparam int GAP = 4;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_mode;
    logic [127:0] req_key, req_nonce, req_ad, req_din;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_dout, rsp_tag;
    logic         rsp_timeout;
    logic         chipselect, write, read;
    logic [4:0]   address;
    logic [31:0]  writedata;
    logic [31:0]  readdata;

    ascon_avmm_host #(.POLL_TIMEOUT(TO), .POLL_GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_key(req_key), .req_nonce(req_nonce), .req_ad(req_ad), .req_din(req_din),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dout(rsp_dout),
        .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout),
        .chipselect(chipselect), .write(write), .read(read), .address(address),
        .writedata(writedata), .readdata(readdata)
    );

    // ---------------- clock / reset / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- slave model ----------------
    int          st_total = 0;   // status reads ever seen
    int          st_base  = 0;   // st_total at start of current job
    int          done_after = 0; // polls answered not-done before done
    logic [31:0] rb [18:25];

    always @(posedge clk) begin
        logic [31:0] rnd;
        logic        done_bit;
        rnd = $urandom;
        done_bit = ((st_total - st_base + 1) > done_after);
        if (read && address == ADDR_STATUS) begin
            st_total <= st_total + 1;
            readdata <= {rnd[31:1], done_bit};
        end else if (read && address >= ADDR_DOUT0 && address <= ADDR_RD_LAST) begin
            readdata <= rb[address];
        end else begin
            readdata <= rnd;
        end
    end

    // ---------------- bus monitor ----------------
    logic [4:0]  wr_a_q [$];
    logic [31:0] wr_d_q [$];
    int          wr_c_q [$];
    logic [4:0]  rd_a_q [$];
    int          rd_c_q [$];
    int          prot_err = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if ((write || read) != chipselect || (write && read)) prot_err <= prot_err + 1;
            if (write) begin
                wr_a_q.push_back(address);
                wr_d_q.push_back(writedata);
                wr_c_q.push_back(cyc);
            end
            if (read) begin
                rd_a_q.push_back(address);
                rd_c_q.push_back(cyc);
            end
        end
    end

    // ---------------- job-level reference model ----------------
    typedef struct {
        logic [1:0]   mode;
        logic [127:0] key, nonce, ad, din;
        int           done_after;
        logic [31:0]  exp_w1, exp_w16, exp_go, exp_clr;
        int           exp_nst;
        logic         exp_to;
    } vec_t;

    function automatic logic [31:0] word_of(input logic [127:0] v, input int j);
        return v[127 - 32 * j -: 32];
    endfunction

    function automatic logic [31:0] ctrl_word(input logic [1:0] m, input logic go);
        return {29'd0, m, go};
    endfunction

    // Status is done on poll number done_after+1; the host gives up after TO polls.
    function automatic int model_nst(input int da);
        return (da < TO) ? da + 1 : TO;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v.mode       = 2'($urandom_range(0, 3));
        v.key        = {$urandom, $urandom, $urandom, $urandom};
        v.nonce      = {$urandom, $urandom, $urandom, $urandom};
        v.ad         = {$urandom, $urandom, $urandom, $urandom};
        v.din        = {$urandom, $urandom, $urandom, $urandom};
        v.done_after = $urandom_range(0, 10);
        v.exp_w1     = word_of(v.key, 0);
        v.exp_w16    = word_of(v.din, 3);
        v.exp_go     = ctrl_word(v.mode, 1'b1);
        v.exp_clr    = ctrl_word(v.mode, 1'b0);
        v.exp_nst    = model_nst(v.done_after);
        v.exp_to     = (v.done_after >= TO);
        return v;
    endfunction

    task automatic pulse_reset();
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_job(input vec_t v, input int bp, input bit early);
        logic [36:0]  exp_q [$];
        logic [4:0]   exp_ra [$];
        int           exp_rc [$];
        logic [127:0] fld [4];
        logic [127:0] exp_dout, exp_tag, s_dout, s_tag;
        logic         s_to;
        int           wb, rdb, acc_cyc, tries, nw, nr, waited, first_st;
        bit           got;

        @(negedge clk);
        for (int k = 18; k <= 25; k++) rb[k] = $urandom;
        done_after = v.done_after;
        st_base    = st_total;
        wb  = wr_a_q.size();
        rdb = rd_a_q.size();

        req_mode = v.mode; req_key = v.key; req_nonce = v.nonce;
        req_ad = v.ad; req_din = v.din; req_valid = 1'b1;
        rsp_ready = early;
        #1;
        tries = 0;
        while (!req_ready && tries < 50) begin
            @(negedge clk); #1; tries++;
        end
        chk("req_accept", req_ready, 1'b1);
        if (!req_ready) begin pulse_reset(); return; end
        acc_cyc = cyc + 1;
        @(negedge clk);
        // Scramble the request bus; the job must use the latched copy.
        req_mode = 2'($urandom_range(0, 3));
        req_key  = {$urandom, $urandom, $urandom, $urandom};
        req_din  = {$urandom, $urandom, $urandom, $urandom};
        req_valid = !early;

        got = 1'b0;
        for (waited = 0; waited < 2000; waited++) begin
            if (rsp_valid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("rsp_arrive", got, 1'b1);
        if (!got) begin pulse_reset(); return; end

        s_dout = rsp_dout; s_tag = rsp_tag; s_to = rsp_timeout;
        exp_dout = v.exp_to ? 128'd0 : {rb[18], rb[19], rb[20], rb[21]};
        exp_tag  = v.exp_to ? 128'd0 : {rb[22], rb[23], rb[24], rb[25]};
        chk("rsp_dout", s_dout, exp_dout);
        chk("rsp_tag", s_tag, exp_tag);
        chk("rsp_timeout", s_to, v.exp_to);

        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("hold_ctl", {rsp_valid, req_ready}, 2'b10);
            chk("hold_data", {rsp_dout, rsp_tag}, {s_dout, s_tag});
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rsp_release", {rsp_valid, req_ready}, 2'b01);
        rsp_ready = 1'b0;
        #1;

        // Expected writes: 16 config words then the start pulse.
        fld[0] = v.key; fld[1] = v.nonce; fld[2] = v.ad; fld[3] = v.din;
        for (int f = 0; f < 4; f++)
            for (int j = 0; j < 4; j++)
                exp_q.push_back({5'(1 + 4 * f + j), word_of(fld[f], j)});
        exp_q.push_back({5'd0, ctrl_word(v.mode, 1'b1)});
        exp_q.push_back({5'd0, ctrl_word(v.mode, 1'b0)});

        nw = wr_a_q.size() - wb;
        chk("wr_count", nw, 18);
        if (nw >= 18) begin
            chk("wr_first", wr_d_q[wb], v.exp_w1);
            chk("wr_last_cfg", wr_d_q[wb + 15], v.exp_w16);
            chk("wr_go", wr_d_q[wb + 16], v.exp_go);
            chk("wr_clr", wr_d_q[wb + 17], v.exp_clr);
        end
        for (int i = 0; i < nw && exp_q.size() > 0; i++) begin
            chk("wr_word", {wr_a_q[wb + i], wr_d_q[wb + i]}, exp_q.pop_front());
            chk("wr_cycle", wr_c_q[wb + i], acc_cyc + i);
        end

        // Expected reads: polls POLL_GAP+2 cycles apart, then 8 back-to-back.
        first_st = acc_cyc + 18;
        for (int j = 0; j < v.exp_nst; j++) begin
            exp_ra.push_back(ADDR_STATUS);
            exp_rc.push_back(first_st + j * (GAP + 2));
        end
        if (!v.exp_to)
            for (int k = 0; k < 8; k++) begin
                exp_ra.push_back(5'(18 + k));
                exp_rc.push_back(first_st + (v.exp_nst - 1) * (GAP + 2) + 2 + k);
            end
        nr = rd_a_q.size() - rdb;
        chk("rd_count", nr, exp_ra.size());
        for (int i = 0; i < nr && exp_ra.size() > 0; i++) begin
            chk("rd_addr", rd_a_q[rdb + i], exp_ra.pop_front());
            chk("rd_cycle", rd_c_q[rdb + i], exp_rc.pop_front());
        end
        chk("protocol", prot_err, 0);
    endtask

    // ---------------- main sequence ----------------
    vec_t tbl [12];
    int   bp;
    bit   early;
    bit   seen;
    int   wb0, rb0;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_mode = '0; req_key = '0; req_nonce = '0; req_ad = '0; req_din = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctl", {chipselect, write, read, rsp_valid, req_ready, rsp_timeout}, 6'd0);
        chk("reset_bus", {address, writedata}, 37'd0);
        chk("reset_rsp", {rsp_dout, rsp_tag}, 256'd0);
        rst_n = 1'b1;
        #1;
        chk("reset_ready", req_ready, 1'b1);

        tbl[0] = '{MODE_ENCRYPT, 128'h1234567890ABCDEF1234567890ABCDEF,
                   128'hFEDCBA9876543210FEDCBA9876543210,
                   128'h0041757468656E74_6963617465642121,
                   128'h436F6E666964656E_7469616C44617461,
                   3, 32'h12345678, 32'h44617461, 32'h1, 32'h0, 4, 1'b0};
        tbl[1] = tbl[0];
        tbl[1].mode = MODE_DECRYPT; tbl[1].done_after = 0;
        tbl[1].exp_go = 32'h3; tbl[1].exp_clr = 32'h2; tbl[1].exp_nst = 1;
        tbl[2] = tbl[0];
        tbl[2].done_after = 100000; tbl[2].exp_nst = 8; tbl[2].exp_to = 1'b1;
        tbl[3] = tbl[0];
        tbl[3].mode = 2'd2; tbl[3].done_after = 7; tbl[3].exp_go = 32'h5;
        tbl[3].exp_clr = 32'h4; tbl[3].exp_nst = 8; tbl[3].exp_to = 1'b0;
        tbl[4] = tbl[0];
        tbl[4].mode = 2'd3; tbl[4].done_after = 8; tbl[4].exp_go = 32'h7;
        tbl[4].exp_clr = 32'h6; tbl[4].exp_nst = 8; tbl[4].exp_to = 1'b1;
        for (int i = 5; i < 12; i++) tbl[i] = rand_vec();

        for (int i = 0; i < 12; i++) begin
            if (i == 0)      begin bp = 10; early = 1'b0; end
            else if (i == 5) begin bp = 0;  early = 1'b1; end
            else             begin bp = $urandom_range(0, 3); early = 1'b0; end
            run_job(tbl[i], bp, early);
        end

        // Reset in the middle of the configuration writes.
        @(negedge clk);
        req_mode = tbl[0].mode; req_key = tbl[0].key; req_nonce = tbl[0].nonce;
        req_ad = tbl[0].ad; req_din = tbl[0].din; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            #1;
            if (write && address == 5'd7) seen = 1'b1;
            else @(negedge clk);
        end
        chk("midreset_reach_idx7", seen, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_bus", {chipselect, write, read, rsp_valid}, 4'd0);
        rst_n = 1'b1;
        #1;
        chk("midreset_ready", req_ready, 1'b1);
        wb0 = wr_a_q.size(); rb0 = rd_a_q.size();
        repeat (6) @(negedge clk);
        #1;
        chk("midreset_quiet", {32'(wr_a_q.size() - wb0), 32'(rd_a_q.size() - rb0), 31'd0, rsp_valid}, 96'd0);
        run_job(tbl[0], 2, 1'b0);
        run_job(rand_vec(), 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ascon_avmm_host.md
Name: ascon_avmm_host

Overview:
- Avalon-MM initiator that drives the ASCON register-mapped core (the ascon_wrapper slave) on behalf of an on-chip client.
- Accepts one complete AEAD job per request handshake: mode, key, nonce, 2×64-bit AD and 2×64-bit data.
- Programs the slave's register map, pulses start, polls status, then reads back output data and tag.
- Returns the result on a valid/ready response channel.

Parameters:
- POLL_TIMEOUT, 1024, maximum status polls before the job aborts with timeout.
- POLL_GAP, 4, idle cycles between consecutive status polls (0 allowed).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  job request valid
- req_ready  out  1  high only in IDLE
- req_mode  in  2  0=encrypt, 1=decrypt, 2/3 forwarded unchanged
- req_key  in  128  key
- req_nonce  in  128  nonce
- req_ad  in  128  {AD0, AD1}
- req_din  in  128  {PT/CT0, PT/CT1}
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result accepted
- rsp_dout  out  128  {out0, out1}
- rsp_tag  out  128  tag
- rsp_timeout  out  1  job aborted by poll timeout
- chipselect  out  1  Avalon chipselect
- write  out  1  Avalon write strobe
- read  out  1  Avalon read strobe
- address  out  5  Avalon word address
- writedata  out  32  Avalon write data
- readdata  in  32  Avalon read data, valid exactly 1 cycle after read high

Behaviour:
- Slave map (word addresses):
  - 0: control {29'b0, mode[1:0], start}
  - 1–4: key[127:96]..key[31:0]
  - 5–8: nonce
  - 9–12: AD
  - 13–16: data in
  - 17: status, bit0 = done
  - 18–21: data out [127:96]..[31:0]
  - 22–25: tag
  - All words are MSW first.
- Reset: all outputs 0, except req_ready=1 when rst_n=1 in IDLE; internal registers cleared; state IDLE. Reset mid-job aborts with no further bus cycles and no response.
- Every bus cycle lasts one clk. chipselect is high whenever write or read is high; write and read are never both high.
- States:
  - IDLE: on req_valid&&req_ready, latch all req_* fields and go to WR_CFG with idx=1.
  - WR_CFG: write address idx with the corresponding latched word; idx 1→16, one per cycle; after 16 go to WR_GO.
  - WR_GO: write addr 0 = {mode,1}.
  - WR_CLR: write addr 0 = {mode,0}; go to POLL_RD.
  - POLL_RD: read addr 17; poll_cnt++.
  - POLL_CAP: sample readdata. If bit0=1, go to RD_OUT idx=18. Else if poll_cnt==POLL_TIMEOUT, go to RESP with rsp_timeout=1 and dout/tag=0. Else go to POLL_WAIT.
  - POLL_WAIT: idle POLL_GAP cycles, then POLL_RD.
  - RD_OUT: issue read idx; readdata for idx is captured on the following cycle, while the next read is issued back-to-back; idx 18→25, 9 cycles total including the final capture; then RESP.
  - RESP: rsp_valid=1 with stable rsp_*; hold until rsp_ready; then IDLE. rsp_ready high before rsp_valid has no effect.
- Write phase latency is 18 cycles. The first poll read occurs in the cycle after WR_CLR.
- poll_cnt is 16 bits wide, saturating, and cleared on request accept.
- req_* changes after acceptance do not affect the job in progress.

Decomposition:
- Package ascon_host_pkg holds:
  - Register address localparams: CTRL=0, KEY0=1, NONCE0=5, AD0=9, DIN0=13, STATUS=17, DOUT0=18, TAG0=22.
  - State enum.
  - Mode encoding constants.
- No sub-module; single FSM plus word-select mux.

Test Plan:
- Encrypt job: key 0x1234567890ABCDEF1234567890ABCDEF, nonce 0xFEDCBA9876543210FEDCBA9876543210, AD {0x0041757468656E74, 0x6963617465642121}, data {0x436F6E666964656E, 0x7469616C44617461}, mode 0 -> write addresses 1..16 carry 0x12345678, 0x90ABCDEF, … 0x44617461 in order; then addr0=0x1, then addr0=0x0.
- Decrypt job: mode 1 -> control writes 0x3 then 0x2.
- Poll handling: status model returns 0 three times then 1; readback model returns 0xA0..0xA7 for addresses 18..25 -> exactly 4 status reads spaced POLL_GAP apart; rsp_dout={0xA0,0xA1,0xA2,0xA3}, rsp_tag={0xA4..0xA7}; rsp_timeout=0.
- Timeout: POLL_TIMEOUT=8, status never done -> exactly 8 status reads; rsp_valid with rsp_timeout=1 and rsp_dout=0, rsp_tag=0; no reads of 18..25.
- Backpressure: rsp_ready low for 10 cycles -> rsp_* stable and req_ready stays 0; a new req_valid is only accepted after the response handshake.
- Reset mid-write at idx 7 -> next cycle chipselect=write=read=0 and req_ready=1; a fresh job then completes normally.
